axi_lite_kernel_launcher: RTL and testbench

AXI_LITE_KERNEL_LAUNCHER -- requirements
Module: axi_lite_kernel_launcher

---
 rtl/axi_lite_kernel_launcher_if.sv | 32 +++
 rtl/axi_lite_kernel_launcher.sv | 189 ++++++++++++++++++
 tb/tb_axi_lite_kernel_launcher.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_kernel_launcher_if.sv
// AXI-lite bundle between the kernel launcher (master) and a control register block (slave).
interface axi_lite_interface #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_kernel_launcher.sv
// Writes kernel arguments and the start bit over AXI-lite, then polls status until done.
// Optional LAUNCH_TIMEOUT_EN bounds polling to MAX_POLLS reads (error_code 3).
module axi_lite_kernel_launcher #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int ARG_WORDS  = 4,
  parameter int POLL_GAP   = 4,
  parameter int MAX_POLLS  = 1024
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  axi_lite_interface.master               axi,
  input  logic                            launch,
  input  logic [DATA_WIDTH*ARG_WORDS-1:0] launch_args,
  output logic                            busy,
  output logic                            finished,
  output logic                            error,
  output logic [1:0]                      error_code
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (ARG_WORDS > 1) ? $clog2(ARG_WORDS) : 1;
  localparam int GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARG_WORDS - 1);
  localparam logic [1:0] OKAY = 2'b00;

  generate
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
      $error("axi_lite_kernel_launcher: DATA_WIDTH must be 32 or 64");
    end
    if (ARG_WORDS < 1) begin : g_bad_args
      $error("axi_lite_kernel_launcher: ARG_WORDS must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE, ARG_W, ARG_B, START_W, START_B, POLL_AR, POLL_R, GAP
  } state_t;

  state_t                                 state;
  logic [IDX_W-1:0]                       idx;
  logic [IDX_W-1:0]                       idx_nxt;
  logic [GAP_W-1:0]                       gap_cnt;
  logic [ARG_WORDS-1:0][DATA_WIDTH-1:0]   args_q;
  logic                                   aw_ok, w_ok;
`ifdef LAUNCH_TIMEOUT_EN
  localparam int PC_W = $clog2(MAX_POLLS + 1);
  logic [PC_W-1:0] poll_cnt;
  logic [PC_W-1:0] poll_nxt;
  assign poll_nxt = poll_cnt + 1'b1;
`endif

  function automatic logic [ADDR_WIDTH-1:0] arg_addr(input logic [IDX_W-1:0] i);
    return ADDR_WIDTH'(32'h10 + 32'(i) * STRB_W);
  endfunction

  assign busy    = (state != IDLE);
  assign idx_nxt = idx + 1'b1;
  // Each channel is done once its valid has dropped or is being accepted this cycle.
  assign aw_ok   = !axi.awvalid || axi.awready;
  assign w_ok    = !axi.wvalid  || axi.wready;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state       <= IDLE;
      idx         <= '0;
      gap_cnt     <= '0;
      args_q      <= '0;
      finished    <= 1'b0;
      error       <= 1'b0;
      error_code  <= 2'd0;
      axi.awaddr  <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      axi.araddr  <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
`ifdef LAUNCH_TIMEOUT_EN
      poll_cnt    <= '0;
`endif
    end else begin
      finished <= 1'b0;
      case (state)
        IDLE: if (launch) begin
          args_q      <= launch_args;
          error       <= 1'b0;
          error_code  <= 2'd0;
          idx         <= '0;
          axi.awaddr  <= arg_addr('0);
          axi.wdata   <= launch_args[DATA_WIDTH-1:0];
          axi.wstrb   <= '1;
          axi.awvalid <= 1'b1;
          axi.wvalid  <= 1'b1;
          state       <= ARG_W;
        end
        ARG_W, START_W: begin
          if (axi.awready) axi.awvalid <= 1'b0;
          if (axi.wready)  axi.wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            axi.bready <= 1'b1;
            state      <= (state == ARG_W) ? ARG_B : START_B;
          end
        end
        ARG_B: if (axi.bvalid) begin
          axi.bready <= 1'b0;
          if (axi.bresp != OKAY) begin
            error      <= 1'b1;
            error_code <= 2'd1;
            state      <= IDLE;
          end else begin
            axi.awvalid <= 1'b1;
            axi.wvalid  <= 1'b1;
            if (idx == LAST_IDX) begin
              axi.awaddr <= '0;
              axi.wdata  <= DATA_WIDTH'(1);
              state      <= START_W;
            end else begin
              idx        <= idx_nxt;
              axi.awaddr <= arg_addr(idx_nxt);
              axi.wdata  <= args_q[idx_nxt];
              state      <= ARG_W;
            end
          end
        end
        START_B: if (axi.bvalid) begin
          axi.bready <= 1'b0;
          if (axi.bresp != OKAY) begin
            error      <= 1'b1;
            error_code <= 2'd1;
            state      <= IDLE;
          end else begin
            axi.araddr  <= '0;
            axi.arvalid <= 1'b1;
`ifdef LAUNCH_TIMEOUT_EN
            poll_cnt    <= '0;
`endif
            state       <= POLL_AR;
          end
        end
        POLL_AR: if (axi.arready) begin
          axi.arvalid <= 1'b0;
          axi.rready  <= 1'b1;
          state       <= POLL_R;
        end
        POLL_R: if (axi.rvalid) begin
          axi.rready <= 1'b0;
          if (axi.rresp != OKAY) begin
            error      <= 1'b1;
            error_code <= 2'd2;
            state      <= IDLE;
          end else if (axi.rdata[1]) begin
            finished <= 1'b1;
            state    <= IDLE;
          end
`ifdef LAUNCH_TIMEOUT_EN
          else if (poll_nxt == PC_W'(MAX_POLLS)) begin
            error      <= 1'b1;
            error_code <= 2'd3;
            state      <= IDLE;
          end
`endif
          else begin
`ifdef LAUNCH_TIMEOUT_EN
            poll_cnt <= poll_nxt;
`endif
            if (POLL_GAP == 0) begin
              axi.arvalid <= 1'b1;
              state       <= POLL_AR;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
            axi.arvalid <= 1'b1;
            state       <= POLL_AR;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_kernel_launcher.sv
// Randomized AXI-lite responder plus per-launch transaction model for the kernel launcher.
module tb_axi_lite_kernel_launcher;
  localparam int AW = 12, DW = 32, NW = 4, PGAP = 4, MAXP = 8;

  logic              ap_clk = 1'b0;
  logic              ap_rst = 1'b1;
  logic              launch = 1'b0;
  logic [DW*NW-1:0]  launch_args = '0;
  logic              busy, finished, error;
  logic [1:0]        error_code;

  axi_lite_interface #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi_if ();

  axi_lite_kernel_launcher #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARG_WORDS(NW), .POLL_GAP(PGAP), .MAX_POLLS(MAXP)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .axi(axi_if), .launch(launch),
    .launch_args(launch_args), .busy(busy), .finished(finished),
    .error(error), .error_code(error_code)
  );

  always #5 ap_clk = ~ap_clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // responder script and logs
  bit              rnd_dly;
  int              aw_wait, w_wait, ar_wait, b_wait, r_wait;
  int              aw_n, w_n, b_n, ar_n, r_pres, b_done, r_done;
  int              b_err_idx, r_err_idx;
  bit              b_hs, r_hs;
  logic [DW-1:0]   st_q[$];
  logic [AW-1:0]   aw_log[$], ar_log[$];
  logic [DW-1:0]   w_log[$];
  // monitor
  int              fin_cnt, busy_at_fin, both_hi, idle_valid, unstable, bad_strb, min_gap, gap_cnt;
  logic            p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
  logic [AW-1:0]   p_awaddr, p_araddr;
  logic [DW-1:0]   p_wdata;

  function automatic int dly();
    return rnd_dly ? int'($urandom_range(0, 3)) : 0;
  endfunction

  initial begin
    axi_if.awready = 0; axi_if.wready = 0; axi_if.bvalid = 0; axi_if.bresp = 0;
    axi_if.arready = 0; axi_if.rvalid = 0; axi_if.rdata = 0; axi_if.rresp = 0;
    forever begin
      @(negedge ap_clk);
      if (ap_rst) begin
        axi_if.awready = 0; axi_if.wready = 0; axi_if.bvalid = 0;
        axi_if.arready = 0; axi_if.rvalid = 0;
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_pres = 0; b_hs = 0; r_hs = 0;
        gap_cnt = -1;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
      end else begin
        if (finished) begin fin_cnt++; if (busy) busy_at_fin++; end
        if (finished && error) both_hi++;
        if (!busy && (axi_if.awvalid || axi_if.wvalid || axi_if.arvalid || axi_if.bready || axi_if.rready))
          idle_valid++;
        if (p_awv && !p_awr && (!axi_if.awvalid || axi_if.awaddr !== p_awaddr)) unstable++;
        if (p_wv  && !p_wr  && (!axi_if.wvalid  || axi_if.wdata  !== p_wdata))  unstable++;
        if (p_arv && !p_arr && (!axi_if.arvalid || axi_if.araddr !== p_araddr)) unstable++;
        if (gap_cnt >= 0) begin
          if (axi_if.arvalid) begin
            if (gap_cnt < min_gap) min_gap = gap_cnt;
            gap_cnt = -1;
          end else if (!busy) gap_cnt = -1;
          else gap_cnt++;
        end
        // write response
        if (b_hs) axi_if.bvalid = 0;
        if (!axi_if.bvalid && ((aw_n < w_n) ? aw_n : w_n) > b_n) begin
          if (b_wait > 0) b_wait--;
          else begin
            axi_if.bvalid = 1;
            axi_if.bresp  = (b_n == b_err_idx) ? 2'b10 : 2'b00;
            b_n++;
            b_wait = dly();
          end
        end
        b_hs = axi_if.bvalid && axi_if.bready;
        if (b_hs) b_done++;
        // read data
        if (r_hs) axi_if.rvalid = 0;
        if (!axi_if.rvalid && ar_n > r_pres) begin
          if (r_wait > 0) r_wait--;
          else begin
            axi_if.rvalid = 1;
            axi_if.rdata  = (r_pres < st_q.size()) ? st_q[r_pres] : '0;
            axi_if.rresp  = (r_pres == r_err_idx) ? 2'b10 : 2'b00;
            r_pres++;
            r_wait = dly();
          end
        end
        r_hs = axi_if.rvalid && axi_if.rready;
        if (r_hs) begin r_done++; gap_cnt = 0; end
        // address / write data acceptance
        if (axi_if.awvalid) begin
          if (aw_wait > 0) begin axi_if.awready = 0; aw_wait--; end else axi_if.awready = 1;
        end else axi_if.awready = 0;
        if (axi_if.awvalid && axi_if.awready) begin aw_log.push_back(axi_if.awaddr); aw_n++; aw_wait = dly(); end
        if (axi_if.wvalid) begin
          if (w_wait > 0) begin axi_if.wready = 0; w_wait--; end else axi_if.wready = 1;
        end else axi_if.wready = 0;
        if (axi_if.wvalid && axi_if.wready) begin
          w_log.push_back(axi_if.wdata); w_n++; w_wait = dly();
          if (axi_if.wstrb !== {(DW/8){1'b1}}) bad_strb++;
        end
        if (axi_if.arvalid) begin
          if (ar_wait > 0) begin axi_if.arready = 0; ar_wait--; end else axi_if.arready = 1;
        end else axi_if.arready = 0;
        if (axi_if.arvalid && axi_if.arready) begin ar_log.push_back(axi_if.araddr); ar_n++; ar_wait = dly(); end
        p_awv = axi_if.awvalid; p_awr = axi_if.awready; p_awaddr = axi_if.awaddr;
        p_wv  = axi_if.wvalid;  p_wr  = axi_if.wready;  p_wdata  = axi_if.wdata;
        p_arv = axi_if.arvalid; p_arr = axi_if.arready; p_araddr = axi_if.araddr;
      end
    end
  end

  // Prepare responder script and counters for a fresh launch (called at posedge+1).
  task automatic setup(input int b_err, input int n_nd, input int r_err, input bit fixed_st, input bit skew);
    b_err_idx = b_err; r_err_idx = r_err;
    st_q.delete();
    for (int i = 0; i < n_nd; i++) st_q.push_back(fixed_st ? 32'h1 : ($urandom & ~32'h2));
    if (n_nd >= 0) st_q.push_back(fixed_st ? 32'h2 : ($urandom | 32'h2));
    aw_log.delete(); w_log.delete(); ar_log.delete();
    aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_pres = 0; b_done = 0; r_done = 0;
    fin_cnt = 0; busy_at_fin = 0; both_hi = 0; idle_valid = 0; unstable = 0; bad_strb = 0;
    min_gap = 1000; gap_cnt = -1;
    aw_wait = skew ? 0 : dly(); w_wait = skew ? 3 : dly();
    ar_wait = dly(); b_wait = dly(); r_wait = dly();
  endtask

  task automatic run(input logic [DW*NW-1:0] args, input int b_err, input int n_nd,
                     input int r_err, input bit fixed_st, input bit skew, input logic [1:0] exp_code);
    int cyc, n_wr, n_rd, bad_ar;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(posedge ap_clk); #1;
    setup(b_err, n_nd, r_err, fixed_st, skew);
    launch_args = args; launch = 1;
    @(posedge ap_clk); #1;
    launch = 0;
    chk("busy_on_launch", busy, 1);
    chk("error_cleared", error, 0);
    chk("code_cleared", error_code, 0);
    cyc = 0;
    while (busy && cyc < 3000) begin @(posedge ap_clk); #1; cyc++; end
    chk("completes_in_time", busy, 0);
    repeat (3) @(posedge ap_clk);
    #1;
    // model: arg writes 0x10+4i, then start write, stopping at the first bad BRESP
    n_wr = (b_err >= 0) ? b_err + 1 : NW + 1;
    n_rd = (b_err >= 0) ? 0 : (r_err >= 0) ? r_err + 1 : (n_nd < 0) ? MAXP : n_nd + 1;
    chk("n_aw", aw_log.size(), n_wr);
    chk("n_w", w_log.size(), n_wr);
    for (int i = 0; i < n_wr && i < aw_log.size() && i < w_log.size(); i++) begin
      ea = (i < NW) ? AW'(16 + 4 * i) : '0;
      ed = (i < NW) ? args[DW*i +: DW] : 32'h1;
      chk($sformatf("awaddr[%0d]", i), aw_log[i], ea);
      chk($sformatf("wdata[%0d]", i), w_log[i], ed);
    end
    chk("n_reads", ar_log.size(), n_rd);
    bad_ar = 0;
    foreach (ar_log[i]) if (ar_log[i] !== '0) bad_ar++;
    chk("araddr_zero", bad_ar, 0);
    chk("finished_cycles", fin_cnt, (exp_code == 0) ? 1 : 0);
    chk("error_flag", error, (exp_code != 0));
    chk("error_code", error_code, exp_code);
    chk("busy_at_finished", busy_at_fin, 0);
    chk("finished_and_error", both_hi, 0);
    chk("valid_while_idle", idle_valid, 0);
    chk("unstable_payload", unstable, 0);
    chk("bad_wstrb", bad_strb, 0);
    if (n_rd > 1) chk("poll_gap_ok", (min_gap >= PGAP), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_finished", finished, 0);
    chk("rst_error", error, 0);
    chk("rst_code", error_code, 0);
    chk("rst_valids", {axi_if.awvalid, axi_if.wvalid, axi_if.arvalid, axi_if.bready, axi_if.rready}, 0);
    ap_rst = 0;

    // fixed arguments, responder always ready, status 1,1,2
    rnd_dly = 0;
    run({32'h44, 32'h33, 32'h22, 32'h11}, -1, 2, -1, 1, 0, 2'd0);

    // randomized launches; first one holds WREADY 3 cycles after AWREADY on arg 0
    rnd_dly = 1;
    for (int k = 0; k < 5; k++)
      run({$urandom, $urandom, $urandom, $urandom}, -1, $urandom_range(0, 3), -1, 0, k == 0, 2'd0);

    // write error on arg 2, then a clean launch clears it
    run({$urandom, $urandom, $urandom, $urandom}, 2, 1, -1, 0, 0, 2'd1);
    run({$urandom, $urandom, $urandom, $urandom}, -1, 1, -1, 0, 0, 2'd0);
    // write error anywhere, including the start write
    run({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, NW), 1, -1, 0, 0, 2'd1);
    // read error on the second poll
    run({$urandom, $urandom, $urandom, $urandom}, -1, 3, 1, 0, 0, 2'd2);
`ifdef LAUNCH_TIMEOUT_EN
    run({$urandom, $urandom, $urandom, $urandom}, -1, -1, -1, 0, 0, 2'd3);
`endif

    // reset while a status read is outstanding
    @(posedge ap_clk); #1;
    setup(-1, -1, -1, 0, 0);
    launch_args = {$urandom, $urandom, $urandom, $urandom}; launch = 1;
    @(posedge ap_clk); #1;
    launch = 0;
    cyc = 0;
    while (!axi_if.arvalid && cyc < 500) begin @(posedge ap_clk); #1; cyc++; end
    chk("arvalid_seen", axi_if.arvalid, 1);
    #1 ap_rst = 1;
    #1;
    chk("rst_mid_arvalid", axi_if.arvalid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rready", axi_if.rready, 0);
    @(posedge ap_clk); #2;
    ap_rst = 0;
    repeat (2) @(posedge ap_clk);
    run({$urandom, $urandom, $urandom, $urandom}, -1, 2, -1, 0, 0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
